trail_stack: RTL and testbench
==============================

TRAIL_STACK -- requirements
Module: trail_stack

Interface
REQ-001 Parameter NUM_VARIABLE, default 128, number of solver variables.
REQ-002 Parameter VARIABLE_INDEX, default 7, bit width of a variable index.
REQ-003 Parameter DEPTH, default NUM_VARIABLE, maximum trail entries.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 push_valid  input  1  request to append an assignment to the trail.
REQ-007 push_var  input  VARIABLE_INDEX  variable being assigned.
REQ-008 push_val  input  1  assigned value.
REQ-009 push_decision  input  1  1 = decision, 0 = BCP implication.
REQ-010 push_ready  output  1  push accepted this cycle when high with push_valid.
REQ-011 bt_start  input  1  single-cycle request to backtrack after a conflict.
REQ-012 bt_busy  output  1  high while backtrack is in progress.
REQ-013 unassign_valid, unassign_var  output  1 / VARIABLE_INDEX  the popped variable, to be cleared in assignment memory.
REQ-014 flip_valid, flip_var, flip_val  output  1 / VARIABLE_INDEX / 1  re-assignment of the flipped decision, to be propagated by BCP.
REQ-015 bt_unsat  output  1  one-cycle pulse: no unflipped decision remains.
REQ-016 count  output  $clog2(DEPTH+1)  current occupancy; full and empty outputs, 1 bit each, derived from count.

Function
REQ-017 Each entry SHALL hold var, val, decision and flipped; a push SHALL write flipped = 0.
REQ-018 The FSM SHALL have states IDLE, POP and FLIP.
REQ-019 push_ready SHALL equal (state == IDLE) && !full && !bt_start; bt_start takes priority over a same-cycle push.
REQ-020 An accepted push SHALL store the entry at index count and increment count at that edge.
REQ-021 A push_valid with push_ready low SHALL be dropped with no state change.
REQ-022 In IDLE, bt_start SHALL transition to POP; bt_start outside IDLE SHALL be ignored.
REQ-023 In POP with empty: bt_unsat = 1 for that cycle, next state IDLE.
REQ-024 In POP with the top entry an unflipped decision: no pop, next state FLIP.
REQ-025 In POP otherwise: unassign_valid = 1, unassign_var = top var, count decrements at the edge, remain in POP.
REQ-026 In FLIP: flip_valid = 1, flip_var = top var, flip_val = inverted top val; at the edge the top val is inverted, flipped is set to 1, and the next state is IDLE.
REQ-027 A flipped decision SHALL be popped like an implication by later backtracks.
REQ-028 Latency: with k poppable entries above an unflipped decision and bt_start at edge E0, unassign pulses occur in cycles 1..k, POP holds in cycle k+1, and flip_valid occurs in cycle k+2.
REQ-029 bt_busy SHALL be high exactly while state is POP or FLIP.
REQ-030 unassign_valid, flip_valid and bt_unsat SHALL be combinational from registered state and the top entry, and mutually exclusive.
REQ-031 count SHALL never exceed DEPTH or wrap below 0.

Reset
REQ-032 Reset low SHALL immediately force state IDLE and count 0, making all pulse outputs and bt_busy 0, empty 1 and full 0.
REQ-033 Reset asserted mid-backtrack SHALL abort it with no further unassign or flip pulses.
REQ-034 Entry contents need no reset.

Structure
REQ-035 A shared package sat_pkg SHALL hold NUM_VARIABLE, VARIABLE_INDEX, the trail entry struct and the trail state enum.
REQ-036 Storage SHALL be a register array so the top entry is readable in the same cycle; no sub-module is required.

Verification
REQ-037 Push (3,1,dec), (5,0,imp), (9,1,imp), then bt_start -> unassign 9, then unassign 5, then flip_var=3 with flip_val=0; count goes 3 -> 1.
REQ-038 Repeat bt_start on that trail -> unassign 3, then bt_unsat in the next cycle; count = 0, empty = 1.
REQ-039 Push DEPTH entries, then one more push_valid -> push_ready = 0, full = 1, count = DEPTH, and the extra entry is dropped.
REQ-040 bt_start together with push_valid in IDLE -> push dropped, backtrack proceeds.
REQ-041 Trail [d(1,1), d(2,0)], bt_start -> flip 2 to 1; second bt_start -> unassign 2, then flip 1 to 0.
REQ-042 Reset pulled low during POP with count 4 -> count = 0, IDLE, and no further pulses.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared solver types: trail entries, trail FSM states, default sizes.
package sat_pkg;

  localparam int NUM_VARIABLE   = 128;
  localparam int VARIABLE_INDEX = 7;

  typedef struct packed {
    logic [VARIABLE_INDEX-1:0] var_idx;
    logic                      val;
    logic                      decision;
    logic                      flipped;
  } trail_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    FLIP = 2'd2
  } trail_state_e;

endpackage

// File: rtl/trail_stack_if.sv
// Push channel into the assignment trail (valid/ready).
interface trail_stack_if;
  import sat_pkg::*;

  logic                      push_valid;
  logic [VARIABLE_INDEX-1:0] push_var;
  logic                      push_val;
  logic                      push_decision;
  logic                      push_ready;

  modport master (
    output push_valid,
    output push_var,
    output push_val,
    output push_decision,
    input  push_ready
  );

  modport slave (
    input  push_valid,
    input  push_var,
    input  push_val,
    input  push_decision,
    output push_ready
  );

endinterface

// File: rtl/trail_stack.sv
// Assignment trail for a DPLL/CDCL solver: push assignments,
// backtrack to the most recent unflipped decision and flip it.
module trail_stack
  import sat_pkg::*;
#(
  parameter int NUM_VARIABLE   = sat_pkg::NUM_VARIABLE,
  parameter int VARIABLE_INDEX = sat_pkg::VARIABLE_INDEX,
  parameter int DEPTH          = NUM_VARIABLE,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  trail_stack_if.slave              push,
  input  logic                      bt_start,
  output logic                      bt_busy,
  output logic                      unassign_valid,
  output logic [VARIABLE_INDEX-1:0] unassign_var,
  output logic                      flip_valid,
  output logic [VARIABLE_INDEX-1:0] flip_var,
  output logic                      flip_val,
  output logic                      bt_unsat,
  output logic [CW-1:0]             count,
  output logic                      full,
  output logic                      empty
);

  trail_state_e state;
  trail_entry_t mem [DEPTH];
  trail_entry_t top;

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;
  logic          push_fire;
  logic          top_dec;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_idx  = count[AW-1:0];
  assign top_idx = wr_idx - AW'(1);
  assign top     = mem[top_idx];
  assign top_dec = top.decision && !top.flipped;

  assign push.push_ready = (state == IDLE) && !full && !bt_start;
  assign push_fire       = push.push_valid && push.push_ready;

  assign bt_busy        = (state == POP) || (state == FLIP);
  assign bt_unsat       = (state == POP) && empty;
  assign unassign_valid = (state == POP) && !empty && !top_dec;
  assign unassign_var   = top.var_idx;
  assign flip_valid     = (state == FLIP);
  assign flip_var       = top.var_idx;
  assign flip_val       = !top.val;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bt_start) begin
            state <= POP;
          end else if (push_fire) begin
            count <= count + CW'(1);
          end
        end
        POP: begin
          if (empty) begin
            state <= IDLE;
          end else if (top_dec) begin
            state <= FLIP;
          end else begin
            count <= count - CW'(1);
          end
        end
        FLIP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Entry payload carries no reset; occupancy alone defines validity.
  always_ff @(posedge clock) begin
    if (push_fire) begin
      mem[wr_idx] <= '{
        var_idx:  push.push_var,
        val:      push.push_val,
        decision: push.push_decision,
        flipped:  1'b0
      };
    end else if (state == FLIP) begin
      mem[top_idx].val     <= !top.val;
      mem[top_idx].flipped <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trail_stack.sv
// Scoreboard bench for trail_stack: expected pulses queued at stimulus.
module tb_trail_stack;
  import sat_pkg::*;

  localparam int DEPTH = 128;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam int K_UN = 0;
  localparam int K_FL = 1;
  localparam int K_US = 2;

  typedef struct {
    int kind;
    int vr;
    int vl;
    int cyc;
  } ev_t;

  logic                      clock;
  logic                      reset;
  logic                      bt_start;
  logic                      bt_busy;
  logic                      unassign_valid;
  logic [VARIABLE_INDEX-1:0] unassign_var;
  logic                      flip_valid;
  logic [VARIABLE_INDEX-1:0] flip_var;
  logic                      flip_val;
  logic                      bt_unsat;
  logic [CW-1:0]             count;
  logic                      full;
  logic                      empty;

  trail_stack_if push_if ();

  trail_stack #(.DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .push           (push_if),
    .bt_start       (bt_start),
    .bt_busy        (bt_busy),
    .unassign_valid (unassign_valid),
    .unassign_var   (unassign_var),
    .flip_valid     (flip_valid),
    .flip_var       (flip_var),
    .flip_val       (flip_val),
    .bt_unsat       (bt_unsat),
    .count          (count),
    .full           (full),
    .empty          (empty)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int base = 0;
  ev_t sb[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Pulse monitor: every pulse must match the scoreboard head.
  always @(negedge clock) begin
    int n;
    int k;
    ev_t e;
    n = int'(unassign_valid) + int'(flip_valid) + int'(bt_unsat);
    if (reset && n > 0) begin
      vectors++;
      k = unassign_valid ? K_UN : (flip_valid ? K_FL : K_US);
      if (n > 1) begin
        miscompares++;
        $display("FAIL exclusive pulses: got %0d high, required 1", n);
      end else if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected pulse kind %0d at cyc %0d", k, cyc);
      end else begin
        e = sb.pop_front();
        if (k != e.kind || e.cyc != cyc
            || (k == K_UN && int'(unassign_var) != e.vr)
            || (k == K_FL && (int'(flip_var) != e.vr
                              || int'(flip_val) != e.vl))) begin
          miscompares++;
          $display("FAIL pulse: got kind=%0d uv=%0d fv=%0d fval=%0d cyc=%0d, required kind=%0d var=%0d val=%0d cyc=%0d",
                   k, unassign_var, flip_var, flip_val, cyc,
                   e.kind, e.vr, e.vl, e.cyc);
        end
      end
    end
  end

  task automatic expect_ev(int kind, int vr, int vl, int k);
    ev_t e;
    e.kind = kind;
    e.vr   = vr;
    e.vl   = vl;
    e.cyc  = base + k;
    sb.push_back(e);
  endtask

  task automatic do_push(int vr, int vl, int dec);
    @(negedge clock);
    push_if.push_valid    = 1'b1;
    push_if.push_var      = VARIABLE_INDEX'(vr);
    push_if.push_val      = vl[0];
    push_if.push_decision = dec[0];
    @(posedge clock);
    #1 push_if.push_valid = 1'b0;
  endtask

  task automatic arm_bt();
    @(negedge clock);
    base = cyc;
  endtask

  task automatic fire_bt();
    bt_start = 1'b1;
    @(posedge clock);
    #1 bt_start = 1'b0;
  endtask

  task automatic wait_idle(string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (!bt_busy) begin
        done = 1'b1;
        break;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s timeout: bt_busy still 1, required 0", name);
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s missing pulses: got %0d left, required 0",
               name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_count(string name, int exp);
    vectors++;
    if (count !== CW'(exp)) begin
      miscompares++;
      $display("FAIL %s count: got %0d, required %0d", name, count, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    vectors++;
    if ({count, empty, full, bt_busy, unassign_valid, flip_valid, bt_unsat}
        !== {CW'(0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset state: got cnt=%0d e=%b f=%b busy=%b, required 0 1 0 0",
               count, empty, full, bt_busy);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if (push_if.push_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset ready: got %b, required 1", push_if.push_ready);
    end
  endtask

  task automatic test_basic();
    do_push(3, 1, 1);
    do_push(5, 0, 0);
    do_push(9, 1, 0);
    @(negedge clock);
    check_count("basic pre", 3);
    arm_bt();
    expect_ev(K_UN, 9, 0, 1);
    expect_ev(K_UN, 5, 0, 2);
    expect_ev(K_FL, 3, 0, 4);
    fire_bt();
    wait_idle("basic");
    check_count("basic post", 1);
  endtask

  task automatic test_unsat();
    arm_bt();
    expect_ev(K_UN, 3, 0, 1);
    expect_ev(K_US, 0, 0, 2);
    fire_bt();
    wait_idle("unsat");
    check_count("unsat", 0);
    vectors++;
    if (empty !== 1'b1) begin
      miscompares++;
      $display("FAIL unsat empty: got %b, required 1", empty);
    end
  endtask

  task automatic test_flip_twice();
    do_push(1, 1, 1);
    do_push(2, 0, 1);
    arm_bt();
    expect_ev(K_FL, 2, 1, 2);
    fire_bt();
    wait_idle("flip1");
    check_count("flip1", 2);
    arm_bt();
    expect_ev(K_UN, 2, 0, 1);
    expect_ev(K_FL, 1, 0, 3);
    fire_bt();
    wait_idle("flip2");
    check_count("flip2", 1);
    arm_bt();
    expect_ev(K_UN, 1, 0, 1);
    expect_ev(K_US, 0, 0, 2);
    fire_bt();
    wait_idle("flip3");
    check_count("flip3", 0);
  endtask

  task automatic test_priority();
    do_push(4, 0, 0);
    arm_bt();
    push_if.push_valid    = 1'b1;
    push_if.push_var      = VARIABLE_INDEX'(6);
    push_if.push_val      = 1'b1;
    push_if.push_decision = 1'b0;
    bt_start = 1'b1;
    #1;
    vectors++;
    if (push_if.push_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL prio ready: got %b, required 0", push_if.push_ready);
    end
    expect_ev(K_UN, 4, 0, 1);
    expect_ev(K_US, 0, 0, 2);
    @(posedge clock);
    #1;
    bt_start = 1'b0;
    push_if.push_valid = 1'b0;
    wait_idle("prio");
    check_count("prio", 0);
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) do_push(i, i % 2, 0);
    @(negedge clock);
    check_count("full", DEPTH);
    vectors++;
    if (full !== 1'b1 || push_if.push_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full flags: got full=%b ready=%b, required 1 0",
               full, push_if.push_ready);
    end
    do_push(77, 1, 1);
    @(negedge clock);
    check_count("full drop", DEPTH);
    arm_bt();
    for (int i = 0; i < DEPTH; i++) expect_ev(K_UN, DEPTH - 1 - i, 0, i + 1);
    expect_ev(K_US, 0, 0, DEPTH + 1);
    fire_bt();
    wait_idle("full drain");
    check_count("full drain", 0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) do_push(20 + i, 1, 0);
    arm_bt();
    expect_ev(K_UN, 23, 0, 1);
    fire_bt();
    @(negedge clock);
    vectors++;
    if (bt_busy !== 1'b1 || count !== CW'(4)) begin
      miscompares++;
      $display("FAIL mid pop: got busy=%b cnt=%0d, required 1 4",
               bt_busy, count);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({bt_busy, unassign_valid, flip_valid, bt_unsat, empty, count}
        !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, CW'(0)}) begin
      miscompares++;
      $display("FAIL mid reset: got busy=%b uv=%b cnt=%0d, required 0 0 0",
               bt_busy, unassign_valid, count);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    check_count("mid after", 0);
    vectors++;
    if (sb.size() != 0 || bt_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid tail: got left=%0d busy=%b, required 0 0",
               sb.size(), bt_busy);
      sb.delete();
    end
  endtask

  initial begin
    bt_start              = 1'b0;
    push_if.push_valid    = 1'b0;
    push_if.push_var      = '0;
    push_if.push_val      = 1'b0;
    push_if.push_decision = 1'b0;
    test_reset();
    test_basic();
    test_unsat();
    test_flip_twice();
    test_priority();
    test_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
